// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo_if
//  Brief    : Processor-side write bus and FIFO status of the UART transmitter.
//  Revision : 1.0
// ============================================================================
interface uart_tx_fifo_if #(
   parameter int LVL_W = 3
);
   logic             wr;
   logic [7:0]       wdata;
   logic             txrdy;
   logic             empty;
   logic [LVL_W-1:0] level;
   logic             ovf;

   modport master (
      output wr, wdata,
      input  txrdy, empty, level, ovf
   );

   modport slave (
      input  wr, wdata,
      output txrdy, empty, level, ovf
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Brief    : UART transmitter with write FIFO, runtime divisor, 5-8 data bits,
//             parity and 1/2 stop bits.
//  Revision : 1.0
// ============================================================================
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int DIV_W = 19,
   parameter int LVL_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] div,
   input  logic [1:0]       dbits,
   input  logic [2:0]       pmode,
   input  logic             stop2,
   uart_tx_fifo_if.slave    bus,
   output logic             busy,
   output logic             tx
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_PAR   = 3'd3,
      S_STOP  = 3'd4
   } state_t;

   logic [7:0]       mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             ovf_q, ovf_d;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] baud_q, baud_d;
   logic [DIV_W-1:0] div_l_q, div_l_d;
   logic [1:0]       dbits_l_q, dbits_l_d;
   logic             par_en_q, par_en_d;
   logic             stop2_l_q, stop2_l_d;
   logic             par_q, par_d;
   logic [7:0]       shift_q, shift_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic             stop_cnt_q, stop_cnt_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;

   logic             full, empty_w, wr_en, pop, load, tick;
   logic [7:0]       mask, masked;
   logic             par_new;
   logic [2:0]       last_bit;

   always_comb begin
      full    = (level_q == LVL_W'(DEPTH));
      empty_w = (level_q == '0);
      wr_en   = bus.wr && !full;
      ovf_d   = bus.wr && full;
      tick    = (baud_q == div_l_q);
      last_bit = {1'b0, dbits_l_q} + 3'd4;

      // Head entry is masked and its parity resolved with the live config at pop time.
      case (dbits)
         2'b00:   mask = 8'h1F;
         2'b01:   mask = 8'h3F;
         2'b10:   mask = 8'h7F;
         default: mask = 8'hFF;
      endcase
      masked = mem_q[rptr_q] & mask;
      case (pmode[1:0])
         2'b00:   par_new = ^masked;
         2'b01:   par_new = ~^masked;
         2'b10:   par_new = 1'b1;
         default: par_new = 1'b0;
      endcase

      state_d    = state_q;
      baud_d     = tick ? '0 : baud_q + DIV_W'(1);
      div_l_d    = div_l_q;
      dbits_l_d  = dbits_l_q;
      par_en_d   = par_en_q;
      stop2_l_d  = stop2_l_q;
      par_d      = par_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      tx_d       = tx_q;
      busy_d     = busy_q;
      load       = 1'b0;

      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            tx_d   = 1'b1;
            load   = !empty_w;
         end
         S_START: begin
            if (tick) begin
               state_d   = S_DATA;
               tx_d      = shift_q[0];
               shift_d   = {1'b0, shift_q[7:1]};
               bit_cnt_d = '0;
            end
         end
         S_DATA: begin
            if (tick) begin
               if (bit_cnt_q == last_bit) begin
                  stop_cnt_d = 1'b0;
                  if (par_en_q) begin
                     state_d = S_PAR;
                     tx_d    = par_q;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  tx_d      = shift_q[0];
                  shift_d   = {1'b0, shift_q[7:1]};
               end
            end
         end
         S_PAR: begin
            if (tick) begin
               state_d = S_STOP;
               tx_d    = 1'b1;
            end
         end
         S_STOP: begin
            if (tick) begin
               if (stop2_l_q && !stop_cnt_q) begin
                  stop_cnt_d = 1'b1;
               end else if (!empty_w) begin
                  load = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase

      pop = load;
      if (load) begin
         state_d   = S_START;
         tx_d      = 1'b0;
         busy_d    = 1'b1;
         baud_d    = '0;
         div_l_d   = div;
         dbits_l_d = dbits;
         par_en_d  = pmode[2];
         stop2_l_d = stop2;
         par_d     = par_new;
         shift_d   = masked;
      end

      wptr_d  = wptr_q + AW'(wr_en);
      rptr_d  = rptr_q + AW'(pop);
      level_d = level_q + LVL_W'(wr_en) - LVL_W'(pop);
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wptr_q] <= bus.wdata;
      end
      if (rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         level_q    <= '0;
         ovf_q      <= 1'b0;
         state_q    <= S_IDLE;
         baud_q     <= '0;
         div_l_q    <= '0;
         dbits_l_q  <= '0;
         par_en_q   <= 1'b0;
         stop2_l_q  <= 1'b0;
         par_q      <= 1'b0;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         level_q    <= level_d;
         ovf_q      <= ovf_d;
         state_q    <= state_d;
         baud_q     <= baud_d;
         div_l_q    <= div_l_d;
         dbits_l_q  <= dbits_l_d;
         par_en_q   <= par_en_d;
         stop2_l_q  <= stop2_l_d;
         par_q      <= par_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.txrdy = !full;
   assign bus.empty = empty_w;
   assign bus.level = level_q;
   assign bus.ovf   = ovf_q;
   assign busy      = busy_q;
   assign tx        = tx_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Brief    : Directed self-checking bench for uart_tx_fifo.
//  Revision : 1.0
// ============================================================================
module tb_uart_tx_fifo;
   localparam int DEPTH = 4;
   localparam int DIV_W = 19;
   localparam int LVL_W = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic [DIV_W-1:0] div;
   logic [1:0]       dbits;
   logic [2:0]       pmode;
   logic             stop2;
   logic             busy;
   logic             tx;

   int n_checks = 0;
   int n_err    = 0;

   uart_tx_fifo_if #(.LVL_W(LVL_W)) bus ();

   uart_tx_fifo #(
      .DEPTH(DEPTH),
      .DIV_W(DIV_W),
      .LVL_W(LVL_W)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .div  (div),
      .dbits(dbits),
      .pmode(pmode),
      .stop2(stop2),
      .bus  (bus),
      .busy (busy),
      .tx   (tx)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Called just after a pop edge; walks every clock of every bit time.
   task automatic check_frame(input string tag, input logic [11:0] bits, input int nbits, input int bdiv);
      for (int i = 0; i < nbits; i++) begin
         for (int c = 0; c <= bdiv; c++) begin
            check_eq($sformatf("%s tx bit%0d", tag, i), {31'd0, tx}, {31'd0, bits[i]});
            check_eq($sformatf("%s busy bit%0d", tag, i), {31'd0, busy}, 32'd1);
            tick();
         end
      end
   endtask

   task automatic set_cfg(input int d, input logic [1:0] db, input logic [2:0] pm, input logic s2);
      div   = DIV_W'(d);
      dbits = db;
      pmode = pm;
      stop2 = s2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lv_exp [6];
      int bad;
      logic [7:0] b;

      rst = 1'b1;
      bus.wr = 1'b0;
      bus.wdata = 8'h00;
      set_cfg(3, 2'b11, 3'b000, 1'b0);
      tick();
      tick();
      check_eq("rst tx",    {31'd0, tx},        32'd1);
      check_eq("rst busy",  {31'd0, busy},      32'd0);
      check_eq("rst txrdy", {31'd0, bus.txrdy}, 32'd1);
      check_eq("rst empty", {31'd0, bus.empty}, 32'd1);
      check_eq("rst level", {29'd0, bus.level}, 32'd0);
      check_eq("rst ovf",   {31'd0, bus.ovf},   32'd0);
      rst = 1'b0;
      tick();

      // 8N1, div=3, 0x55
      bus.wr = 1'b1;
      bus.wdata = 8'h55;
      tick();
      bus.wr = 1'b0;
      check_eq("8n1 level after wr", {29'd0, bus.level}, 32'd1);
      check_eq("8n1 empty after wr", {31'd0, bus.empty}, 32'd0);
      check_eq("8n1 tx before pop",  {31'd0, tx},        32'd1);
      check_eq("8n1 busy before pop",{31'd0, busy},      32'd0);
      tick();
      check_eq("8n1 empty after pop", {31'd0, bus.empty}, 32'd1);
      check_frame("8n1", 12'b0010_1010_1010, 10, 3);
      check_eq("8n1 busy end", {31'd0, busy}, 32'd0);
      check_eq("8n1 tx end",   {31'd0, tx},   32'd1);

      // 7E1, 0xC1: bit7 ignored, parity 0
      set_cfg(1, 2'b10, 3'b100, 1'b0);
      bus.wr = 1'b1;
      bus.wdata = 8'hC1;
      tick();
      bus.wr = 1'b0;
      tick();
      check_frame("7e1", 12'b0010_1000_0010, 10, 1);
      check_eq("7e1 busy end", {31'd0, busy}, 32'd0);

      // 5O2, 0x07: data 11100, odd parity 0, two stop bits
      set_cfg(2, 2'b00, 3'b101, 1'b1);
      bus.wr = 1'b1;
      bus.wdata = 8'h07;
      tick();
      bus.wr = 1'b0;
      tick();
      check_frame("5o2", 12'b0001_1000_1110, 9, 2);
      check_eq("5o2 busy end", {31'd0, busy}, 32'd0);

      // Overrun: six back-to-back writes, div=1, 8N1
      set_cfg(1, 2'b11, 3'b000, 1'b0);
      lv_exp = '{1, 1, 2, 3, 4, 4};
      for (int i = 0; i < 6; i++) begin
         bus.wr = 1'b1;
         bus.wdata = 8'(8'h41 + i);
         tick();
         check_eq($sformatf("ovr level edge%0d", i + 1), {29'd0, bus.level}, 32'(lv_exp[i]));
      end
      bus.wr = 1'b0;
      check_eq("ovr ovf pulse", {31'd0, bus.ovf},   32'd1);
      check_eq("ovr txrdy full",{31'd0, bus.txrdy}, 32'd0);
      tick();
      check_eq("ovr ovf cleared", {31'd0, bus.ovf},   32'd0);
      check_eq("ovr txrdy still", {31'd0, bus.txrdy}, 32'd0);
      check_eq("ovr A bit1",      {31'd0, tx},        32'd0);
      repeat (15) tick();
      for (int j = 0; j < 4; j++) begin
         b = 8'(8'h42 + j);
         check_eq($sformatf("ovr level pop%0d", j), {29'd0, bus.level}, 32'(3 - j));
         check_eq($sformatf("ovr empty pop%0d", j), {31'd0, bus.empty}, (j == 3) ? 32'd1 : 32'd0);
         check_frame($sformatf("ovr frame%0d", j), {2'b00, 1'b1, b, 1'b0}, 10, 1);
      end
      check_eq("ovr busy end", {31'd0, busy}, 32'd0);

      // Config change mid-frame
      set_cfg(1, 2'b11, 3'b000, 1'b0);
      bus.wr = 1'b1;
      bus.wdata = 8'h3C;
      tick();
      bus.wdata = 8'h5A;
      tick();
      bus.wr = 1'b0;
      set_cfg(0, 2'b00, 3'b000, 1'b0);
      check_frame("cfg f1", {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 1);
      check_frame("cfg f2", 12'b0000_0111_0100, 7, 0);
      check_eq("cfg busy end", {31'd0, busy}, 32'd0);

      // Reset mid-frame during data bit 3 with two entries queued
      set_cfg(1, 2'b11, 3'b000, 1'b0);
      bus.wr = 1'b1;
      bus.wdata = 8'hA5;
      tick();
      bus.wdata = 8'h5A;
      tick();
      bus.wdata = 8'hFF;
      tick();
      bus.wr = 1'b0;
      repeat (7) tick();
      check_eq("rmf level before", {29'd0, bus.level}, 32'd2);
      check_eq("rmf busy before",  {31'd0, busy},      32'd1);
      check_eq("rmf tx bit3",      {31'd0, tx},        32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("rmf tx",    {31'd0, tx},        32'd1);
      check_eq("rmf busy",  {31'd0, busy},      32'd0);
      check_eq("rmf level", {29'd0, bus.level}, 32'd0);
      check_eq("rmf empty", {31'd0, bus.empty}, 32'd1);
      bad = 0;
      repeat (30) begin
         tick();
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      check_eq("rmf quiet after", 32'(bad), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
